// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module  : pc_redirect_ctrl_pkg
// Brief   : Shared PC-select flag codes and redirect FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

    // PC-select codes driven by branch control
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;
    localparam logic [1:0] PC_SYS  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

endpackage : pc_redirect_ctrl_pkg

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module  : pc_redirect_ctrl
// Brief   : Fetch PC register with redirect/flush/halt FSM.
//           Optional macro PC_REDIRECT_PERF_EN adds the redirectCount port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  flag,
    input  logic        stall,
    input  logic [31:0] branchTarget,
    input  logic [31:0] jalrTarget,
    input  logic [31:0] exPc,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        flushIFID,
    output logic        flushIDEX,
    output logic        halted
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0] redirectCount
`endif
);

    localparam logic [1:0] c_cnt_init = 2'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic        r_flush;
    logic        r_halted;
`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] r_redirect_cnt;
`endif

    logic [31:0] w_pc_inc;
    assign w_pc_inc = r_pc + 32'd4;

    // Flush/halted are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_RUN;
            r_cnt    <= 2'd0;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    case (flag)
                        PC_BR: begin
                            r_pc     <= branchTarget;
                            r_state  <= ST_FLUSH;
                            r_cnt    <= c_cnt_init;
                            r_flush  <= 1'b1;
                            r_halted <= 1'b0;
                        end
                        PC_JALR: begin
                            r_pc     <= jalrTarget & ~32'd1;
                            r_state  <= ST_FLUSH;
                            r_cnt    <= c_cnt_init;
                            r_flush  <= 1'b1;
                            r_halted <= 1'b0;
                        end
                        PC_SYS: begin
                            r_pc     <= exPc + 32'd4;
                            r_state  <= ST_HALT;
                            r_flush  <= 1'b1;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            if (!stall) begin
                                r_pc <= w_pc_inc;
                            end
                            r_flush  <= 1'b0;
                            r_halted <= 1'b0;
                        end
                    endcase
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        r_pc <= w_pc_inc;
                    end
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 2'd1;
                        r_flush <= 1'b1;
                    end
                    r_halted <= 1'b0;
                end
                ST_HALT: begin
                    // fetch resumes from the exPc+4 captured on entry
                    if (resume) begin
                        r_state  <= ST_RUN;
                        r_flush  <= 1'b0;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_flush  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= 32'd0;
        end else if (r_state == ST_RUN && flag != PC_SEQ) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end
    assign redirectCount = r_redirect_cnt;
`endif

    assign pc        = r_pc;
    assign flushIFID = r_flush;
    assign flushIDEX = r_flush;
    assign halted    = r_halted;

endmodule : pc_redirect_ctrl

`default_nettype wire
